// File: rtl/nts_dispatch_pkg.sv
// nts_dispatch_pkg: shared encodings and widths for the NTS receive dispatcher.
package nts_dispatch_pkg;
    localparam int DISPATCH_WORD_WIDTH = 64;
    localparam int DISPATCH_MASK_WIDTH = 8;
    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL} buf_state_e;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_e;
endpackage

// File: rtl/nts_rx_dispatcher_buf.sv
// nts_rx_dispatcher_buf: 2^ADDR_WIDTH x 64 synchronous RAM; a read of the address being written returns the new word.
module nts_rx_dispatcher_buf
    import nts_dispatch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [ADDR_WIDTH-1:0]          i_waddr,
    input  logic [DISPATCH_WORD_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0]          i_raddr,
    output logic [DISPATCH_WORD_WIDTH-1:0] o_rdata
);
    logic [DISPATCH_WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        o_rdata <= (i_we && i_waddr == i_raddr) ? i_wdata : mem[i_raddr];
    end
endmodule

// File: rtl/nts_rx_dispatcher.sv
// nts_rx_dispatcher: ping-pong frame buffer between MAC RX and nts_engine.
// Define NTS_RX_DISPATCHER_STATS_EN to add saturating frame statistics outputs.
module nts_rx_dispatcher
    import nts_dispatch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_areset_n,
    input  logic [DISPATCH_MASK_WIDTH-1:0] i_mac_rx_data_valid,
    input  logic [DISPATCH_WORD_WIDTH-1:0] i_mac_rx_data,
    input  logic                           i_mac_rx_good,
    input  logic                           i_mac_rx_bad,
    output logic                           o_dispatch_packet_available,
    input  logic                           i_dispatch_packet_read_discard,
    output logic [DISPATCH_MASK_WIDTH-1:0] o_dispatch_data_valid,
    output logic                           o_dispatch_fifo_empty,
    input  logic                           i_dispatch_fifo_rd_en,
    output logic [DISPATCH_WORD_WIDTH-1:0] o_dispatch_fifo_rd_data
`ifdef NTS_RX_DISPATCHER_STATS_EN
    ,
    output logic [31:0]                    o_stat_frames_good,
    output logic [31:0]                    o_stat_frames_bad,
    output logic [31:0]                    o_stat_frames_overflow,
    output logic [31:0]                    o_stat_frames_busy_drop
`endif
);
    localparam int PW = ADDR_WIDTH + 1;

    wr_state_e                      w_state_q, w_state_d;
    buf_state_e                     buf_q [2], buf_d [2];
    logic                           wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                  count_q [2], count_d [2];
    logic [DISPATCH_MASK_WIDTH-1:0] mask_q [2], mask_d [2];
    logic [DISPATCH_MASK_WIDTH-1:0] last_mask_q, last_mask_d;
    logic                           avail_q, avail_d;
    logic [DISPATCH_WORD_WIDTH-1:0] ram_rdata [2];
    logic [1:0]                     ram_we;
    logic word, eof, start, busy, ovf, accept, in_frame, commit, reject, empty, pop, discard;

    assign word     = |i_mac_rx_data_valid;
    assign eof      = i_mac_rx_good || i_mac_rx_bad;
    assign start    = w_state_q == W_IDLE && word && buf_q[wr_sel_q] == BUF_EMPTY;
    assign busy     = w_state_q == W_IDLE && word && buf_q[wr_sel_q] != BUF_EMPTY;
    assign ovf      = w_state_q == W_FILL && word && wr_ptr_q[ADDR_WIDTH];
    assign accept   = start || (w_state_q == W_FILL && word && !ovf);
    // A frame is live when it holds at least one stored word and has not overflowed.
    assign in_frame = start || (w_state_q == W_FILL && !ovf);
    assign commit   = in_frame && i_mac_rx_good;
    assign reject   = in_frame && !i_mac_rx_good && i_mac_rx_bad;
    assign empty    = rd_ptr_q == count_q[rd_sel_q];
    assign pop      = avail_q && i_dispatch_fifo_rd_en && !empty;
    assign discard  = avail_q && i_dispatch_packet_read_discard;

    always_comb begin
        w_state_d   = eof ? W_IDLE : start ? W_FILL : (busy || ovf) ? W_DROP : w_state_q;
        wr_ptr_d    = w_state_d == W_FILL ? wr_ptr_q + PW'(accept) : '0;
        last_mask_d = accept ? i_mac_rx_data_valid : last_mask_q;
        wr_sel_d    = wr_sel_q ^ commit;
        buf_d       = buf_q;
        count_d     = count_q;
        mask_d      = mask_q;
        if (start) buf_d[wr_sel_q] = BUF_FILLING;
        if (commit) begin
            buf_d[wr_sel_q]   = BUF_FULL;
            count_d[wr_sel_q] = wr_ptr_q + PW'(accept);
            mask_d[wr_sel_q]  = last_mask_d;
        end
        if (reject || ovf) buf_d[wr_sel_q] = BUF_EMPTY;
        if (discard) buf_d[rd_sel_q] = BUF_EMPTY;
        rd_sel_d = rd_sel_q ^ discard;
        rd_ptr_d = discard ? '0 : rd_ptr_q + PW'(pop);
        // Discard forces one idle cycle before the other buffer is presented.
        avail_d  = buf_d[rd_sel_d] == BUF_FULL && !discard;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            w_state_q   <= W_IDLE;
            buf_q       <= '{default: BUF_EMPTY};
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '{default: '0};
            mask_q      <= '{default: '0};
            last_mask_q <= '0;
            avail_q     <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            buf_q       <= buf_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mask_q      <= mask_d;
            last_mask_q <= last_mask_d;
            avail_q     <= avail_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        assign ram_we[g] = accept && wr_sel_q == 1'(g);
        nts_rx_dispatcher_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf (
            .i_clk   (i_clk),
            .i_we    (ram_we[g]),
            .i_waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
            .i_wdata (i_mac_rx_data),
            .i_raddr (rd_ptr_d[ADDR_WIDTH-1:0]),
            .o_rdata (ram_rdata[g])
        );
    end

    assign o_dispatch_packet_available = avail_q;
    assign o_dispatch_data_valid       = avail_q ? mask_q[rd_sel_q] : '0;
    assign o_dispatch_fifo_empty       = !avail_q || empty;
    assign o_dispatch_fifo_rd_data     = avail_q ? ram_rdata[rd_sel_q] : '0;

`ifdef NTS_RX_DISPATCHER_STATS_EN
    logic             zero_frame;
    logic [3:0]       stat_ev;
    logic [3:0][31:0] stat_q;

    assign zero_frame = w_state_q == W_IDLE && !word && eof;
    assign stat_ev    = {busy, ovf, reject || zero_frame, commit};

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) stat_q <= '0;
        else for (int k = 0; k < 4; k++) if (stat_ev[k] && stat_q[k] != '1) stat_q[k] <= stat_q[k] + 32'd1;
    end

    assign o_stat_frames_good      = stat_q[0];
    assign o_stat_frames_bad       = stat_q[1];
    assign o_stat_frames_overflow  = stat_q[2];
    assign o_stat_frames_busy_drop = stat_q[3];
`endif
endmodule

// File: tb/tb_nts_rx_dispatcher.sv
// tb_nts_rx_dispatcher: directed scoreboard bench for the receive dispatcher.
module tb_nts_rx_dispatcher;
    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic [7:0]  mac_dv = '0;
    logic [63:0] mac_data = '0;
    logic        mac_good = 1'b0, mac_bad = 1'b0;
    logic        avail, discard = 1'b0, empty, rd_en = 1'b0;
    logic [7:0]  dvo;
    logic [63:0] rd_data;
    int          checks = 0, errors = 0;
    logic [63:0] exp_words [$];
    int          exp_len [$];
    logic [7:0]  exp_mask [$];

    always #5 clk = ~clk;

    nts_rx_dispatcher #(.ADDR_WIDTH(8)) dut (
        .i_clk                          (clk),
        .i_areset_n                     (areset_n),
        .i_mac_rx_data_valid            (mac_dv),
        .i_mac_rx_data                  (mac_data),
        .i_mac_rx_good                  (mac_good),
        .i_mac_rx_bad                   (mac_bad),
        .o_dispatch_packet_available    (avail),
        .i_dispatch_packet_read_discard (discard),
        .o_dispatch_data_valid          (dvo),
        .o_dispatch_fifo_empty          (empty),
        .i_dispatch_fifo_rd_en          (rd_en),
        .o_dispatch_fifo_rd_data        (rd_data)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkword(input int seed, input int i);
        return {32'(seed), 32'(i)} ^ 64'hA5C3_0F1E_7788_9900;
    endfunction

    task automatic send_frame(input int seed, input int n, input logic [7:0] lmask,
                              input bit good, input bit eof_with_last, input bit stored);
        for (int i = 0; i < n; i++) begin
            mac_dv   = (i == n - 1) ? lmask : 8'hFF;
            mac_data = mkword(seed, i);
            if (i == n - 1 && eof_with_last) begin
                mac_good = good;
                mac_bad  = !good;
            end
            tick();
        end
        mac_dv = '0; mac_data = '0; mac_good = 1'b0; mac_bad = 1'b0;
        if (!eof_with_last) begin
            mac_good = good;
            mac_bad  = !good;
            tick();
            mac_good = 1'b0;
            mac_bad  = 1'b0;
        end
        if (stored) begin
            for (int i = 0; i < n; i++) exp_words.push_back(mkword(seed, i));
            exp_len.push_back(n);
            exp_mask.push_back(lmask);
        end
    endtask

    task automatic read_frame(input string tag, input int nread);
        int waited = 0;
        int len;
        logic [7:0]  m;
        logic [63:0] w;
        while (!avail && waited < 50) begin
            tick();
            waited++;
        end
        chk({tag, " available"}, avail, 1);
        if (exp_len.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed no expected frame, expected one queued", tag);
            return;
        end
        len = exp_len.pop_front();
        m   = exp_mask.pop_front();
        chk({tag, " data_valid"}, dvo, m);
        for (int i = 0; i < len; i++) begin
            w = exp_words.pop_front();
            if (i < nread) begin
                chk($sformatf("%s empty_before[%0d]", tag, i), empty, 0);
                chk($sformatf("%s rd_data[%0d]", tag, i), rd_data, w);
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
            end
        end
        if (nread >= len) begin
            chk({tag, " empty_end"}, empty, 1);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk({tag, " empty_hold"}, empty, 1);
        end
        discard = 1'b1;
        tick();
        discard = 1'b0;
        chk({tag, " available_drop"}, avail, 0);
    endtask

    initial begin
        int hi;
        #2;
        chk("reset available", avail, 0);
        chk("reset data_valid", dvo, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset fifo_empty", empty, 1);
        tick();
        tick();
        areset_n = 1'b1;
        tick();

        send_frame(1, 12, 8'h03, 1, 0, 1);
        chk("ntp available_after_good", avail, 1);
        read_frame("ntp", 12);

        send_frame(2, 12, 8'h03, 0, 0, 0);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (avail) hi++;
            tick();
        end
        chk("bad never_available", hi, 0);

        send_frame(3, 12, 8'h03, 1, 0, 1);
        send_frame(4, 5, 8'h0F, 1, 1, 1);
        send_frame(5, 3, 8'h01, 1, 1, 0);
        read_frame("b2b f1", 12);
        tick();
        chk("b2b reassert", avail, 1);
        read_frame("b2b f2", 5);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (avail) hi++;
            tick();
        end
        chk("b2b f3 dropped", hi, 0);

        send_frame(6, 257, 8'hFF, 1, 0, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (avail) hi++;
            tick();
        end
        chk("overflow never_available", hi, 0);
        send_frame(7, 12, 8'h03, 1, 0, 1);
        read_frame("post_ovf", 12);

        send_frame(8, 1, 8'h7F, 1, 1, 1);
        read_frame("one_word", 1);

        send_frame(9, 12, 8'h03, 1, 0, 1);
        send_frame(10, 7, 8'hFF, 1, 1, 1);
        read_frame("partial", 3);
        read_frame("after_partial", 7);

        send_frame(11, 4, 8'h0F, 1, 1, 0);
        chk("pre_reset available", avail, 1);
        for (int i = 0; i < 5; i++) begin
            mac_dv   = 8'hFF;
            mac_data = mkword(12, i);
            tick();
        end
        #3;
        areset_n = 1'b0;
        #1;
        chk("async_reset available", avail, 0);
        chk("async_reset data_valid", dvo, 0);
        chk("async_reset rd_data", rd_data, 0);
        chk("async_reset fifo_empty", empty, 1);
        mac_dv = '0;
        mac_data = '0;
        tick();
        tick();
        areset_n = 1'b1;
        tick();
        chk("post_reset available", avail, 0);
        send_frame(13, 12, 8'h03, 1, 0, 1);
        read_frame("post_reset", 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nts_rx_dispatcher.md
Name: nts_rx_dispatcher

Overview:
- Receive-side frame buffer that sits between the Ethernet MAC RX stream and nts_engine.
- Accepts 64-bit MAC words with byte-valid strobes and stores whole frames in two ping-pong buffers.
- Presents one complete, good frame at a time to the engine over the dispatch interface: packet_available, data_valid, fifo_empty, rd_en, rd_data, read_discard.
- Lets the MAC fill one buffer while the engine processes the other.

Parameters:
- ADDR_WIDTH, 8, log2 of words per buffer (256 x 64 bit = 2048 bytes per buffer).

Ports:
- i_clk  in  1  system clock
- i_areset_n  in  1  asynchronous active-low reset
- i_mac_rx_data_valid  in  8  byte strobes. Nonzero = word valid. 8'hFF for all but the last word; last word valid bytes are contiguous from bit 0.
- i_mac_rx_data  in  64  frame word. First byte of the frame is in [63:56].
- i_mac_rx_good  in  1  end-of-frame pulse, frame OK (same cycle as, or later than, the last word)
- i_mac_rx_bad  in  1  end-of-frame pulse, frame errored
- o_dispatch_packet_available  out  1  read buffer holds a complete frame
- i_dispatch_packet_read_discard  in  1  engine done with frame; release the buffer
- o_dispatch_data_valid  out  8  byte mask of the frame's last word
- o_dispatch_fifo_empty  out  1  no unread words remain in the current frame
- i_dispatch_fifo_rd_en  in  1  pop current word
- o_dispatch_fifo_rd_data  out  64  current word, first-word-fall-through

Behaviour:
- Reset (async, i_areset_n=0):
  - Outputs: available=0, data_valid=0, rd_data=0, fifo_empty=1.
  - Both buffers EMPTY; wr_sel=rd_sel=0; all pointers 0.
  - A frame in progress at reset is lost.
- Per-buffer state: EMPTY -> FILLING -> FULL -> EMPTY.
- Write FSM states: W_IDLE, W_FILL, W_DROP.
- W_IDLE:
  - First valid MAC word while buffer[wr_sel] is EMPTY: write it at address 0 and go to W_FILL.
  - If buffer[wr_sel] is not EMPTY (both buffers busy): go to W_DROP.
- W_FILL:
  - Each valid word is written at wr_ptr, then wr_ptr++.
  - Record the last nonzero data_valid mask.
  - A word arriving at wr_ptr == 2^ADDR_WIDTH (overflow): go to W_DROP and return buffer[wr_sel] to EMPTY.
- End of frame in W_FILL:
  - i_mac_rx_good: word count and mask latched, buffer FULL, wr_sel toggles, back to W_IDLE.
  - i_mac_rx_bad: buffer returns to EMPTY, back to W_IDLE.
  - If good/bad arrives in the same cycle as a data word, that word is included first.
- W_DROP: ignore data until good/bad, then W_IDLE.
- Read side:
  - available = (buffer[rd_sel]==FULL). It rises 1 cycle after the good pulse when that buffer is rd_sel.
  - rd_data shows mem[rd_ptr] (registered prefetch).
  - fifo_empty = (rd_ptr == word_count).
  - rd_en while !empty: rd_ptr++; the next word is valid on the next cycle.
  - rd_en while empty, or while !available: ignored.
- Discard pulse while available (legal at any point, including mid-read):
  - Buffer[rd_sel] becomes EMPTY, rd_sel toggles, rd_ptr=0.
  - available drops the next cycle and, if the other buffer is FULL, re-asserts 1 cycle later.
  - Discard while !available is ignored.
- Simultaneous events:
  - Discard and good in the same cycle for the same buffer index cannot occur: write and read indices differ when both are active.
  - Commit and release of different buffers in the same cycle are both honoured.
- Zero-word frame (good with no data): treated as bad, buffer stays EMPTY.

Optional Feature:
- Macro: NTS_RX_DISPATCHER_STATS_EN.
- Defined: adds four 32-bit saturating outputs o_stat_frames_good, o_stat_frames_bad, o_stat_frames_overflow, o_stat_frames_busy_drop. Each increments 1 cycle after its terminating event; all reset to 0.
- Undefined: the ports and counters are absent; no other behaviour change.

Decomposition:
- Shared package nts_dispatch_pkg holds:
  - buffer state encoding (EMPTY/FILLING/FULL);
  - write FSM encoding;
  - DISPATCH_WORD_WIDTH=64 and DISPATCH_MASK_WIDTH=8.
- One natural sub-module, nts_rx_dispatcher_buf: a single-port-write/single-port-read 2^ADDR_WIDTH x 64 synchronous RAM, instantiated twice.

Test Plan:
- 90-byte NTP/IPv4/UDP frame (11 full words, then a 2-byte tail with mask 8'h03, then good) -> available=1 one cycle after good. 12 words read in order, data_valid=8'h03, fifo_empty=1 after the 12th pop. Discard -> available=0 next cycle.
- Same frame ended with bad -> available stays 0 for 100 cycles; stats_bad=1 (STATS_EN).
- Three back-to-back good frames, engine not reading -> frames 1 and 2 buffered, frame 3 dropped (busy_drop=1). After discard, frame 2 presented with its own mask.
- Frame of 2^ADDR_WIDTH+1 words then good -> never presented; overflow=1; the following 90-byte frame is received intact.
- Discard after 3 of 12 words read -> rd_ptr resets; the next FULL frame is presented from word 0.
- i_areset_n low mid-frame and while available=1 -> all outputs at reset values immediately; the next good frame is presented normally.
